div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring division on operand magnitudes, one quotient
// bit per cycle, with short-cut completion for divide-by-zero and signed overflow.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd_addr,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_en
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic             rem_sel_reg;
  logic [4:0]       rd_reg;
  logic [WIDTH-1:0] quo_reg, rem_reg, dsr_reg;
  logic             neg_q_reg, neg_r_reg, special_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] wb_data_reg;
  logic [4:0]       wb_addr_reg;

  logic             accept, finish;
  logic             is_signed, a_neg, b_neg, div_zero, overflow;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   partial, diff;
  logic [WIDTH-1:0] step_rem, q_fin, r_fin;

  assign accept = start && !flush && (state_reg != CALC);
  assign finish = (state_reg == CALC) && !flush &&
                  (special_reg || (count_reg == CW'(WIDTH)));

  // Operand preparation at accept time: signs, magnitudes, special cases
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & rs1_data[WIDTH-1];
    b_neg     = is_signed & rs2_data[WIDTH-1];
    a_mag     = a_neg ? -rs1_data : rs1_data;
    b_mag     = b_neg ? -rs2_data : rs2_data;
    div_zero  = (rs2_data == '0);
    overflow  = is_signed && (rs1_data == MIN_NEG) && (rs2_data == '1);
  end

  // One restoring step: shift next dividend bit into the partial remainder
  always_comb begin
    partial  = {rem_reg, quo_reg[WIDTH-1]};
    diff     = partial - {1'b0, dsr_reg};
    step_rem = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    q_fin    = neg_q_reg ? -quo_reg : quo_reg;
    r_fin    = neg_r_reg ? -rem_reg : rem_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC: begin
        if (flush)       state_next = IDLE;
        else if (finish) state_next = DONE;
      end
      DONE:    state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_sel_reg <= 1'b0;
      rd_reg      <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dsr_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      special_reg <= 1'b0;
      count_reg   <= '0;
      wb_data_reg <= '0;
      wb_addr_reg <= '0;
    end else if (accept) begin
      rem_sel_reg <= op[1];
      rd_reg      <= rd_addr;
      dsr_reg     <= b_mag;
      count_reg   <= '0;
      special_reg <= div_zero || overflow;
      // Special cases preload the final quotient/remainder with no sign fix-up
      if (div_zero) begin
        quo_reg   <= '1;
        rem_reg   <= rs1_data;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else if (overflow) begin
        quo_reg   <= MIN_NEG;
        rem_reg   <= '0;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else begin
        quo_reg   <= a_mag;
        rem_reg   <= '0;
        neg_q_reg <= a_neg ^ b_neg;
        neg_r_reg <= a_neg;
      end
    end else if (state_reg == CALC && !flush) begin
      if (finish) begin
        wb_data_reg <= rem_sel_reg ? r_fin : q_fin;
        wb_addr_reg <= rd_reg;
      end else begin
        quo_reg   <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
        rem_reg   <= step_rem;
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign busy    = (state_reg == CALC);
  assign done    = (state_reg == DONE);
  assign wb_data = wb_data_reg;
  assign wb_addr = wb_addr_reg;
  assign wb_en   = done && (wb_addr_reg != '0);

endmodule
